// File: rtl/packer_if.sv
// packer_if: beat-in / word-out stream bundle for the writeback packer.
// The packer sits on the slave side; the PE array feed and the AXI-stream
// write side together form the master.
interface packer_if #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 512,
    parameter int MAX_CNT      = OUTPUT_WIDTH / INPUT_WIDTH
);
    logic [INPUT_WIDTH-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [OUTPUT_WIDTH-1:0] out_data;
    logic [MAX_CNT-1:0]      out_keep;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush_done;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid, flush_done
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid, flush_done
    );
endinterface

// File: rtl/packer.sv
// packer: accumulates MAX_CNT narrow beats (lane 0 at the LSBs) into one wide
// word, with a flush path that closes a partial, zero-padded word and marks
// its valid lanes in out_keep. One output register stage with a
// ready/valid handshake.
module packer #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 512,
    parameter int MAX_CNT      = OUTPUT_WIDTH / INPUT_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    packer_if.slave bus
);
    localparam int                 CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0]   LAST_LANE = CNT_W'(MAX_CNT - 1);
    localparam logic [MAX_CNT-1:0] KEEP_ALL  = '1;

    // Mask with the lowest n lanes set, i.e. (1<<n)-1.
    function automatic logic [MAX_CNT-1:0] lane_mask(input logic [CNT_W-1:0] n);
        logic [MAX_CNT-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_CNT; k++) begin
            m[k] = (k < int'(n));
        end
        return m;
    endfunction

    // Copy of word with lane `lane` replaced by beat.
    function automatic logic [OUTPUT_WIDTH-1:0] lane_insert(
        input logic [OUTPUT_WIDTH-1:0] word,
        input logic [CNT_W-1:0]        lane,
        input logic [INPUT_WIDTH-1:0]  beat
    );
        logic [OUTPUT_WIDTH-1:0] w;
        w = word;
        for (int k = 0; k < MAX_CNT; k++) begin
            if (lane == CNT_W'(k)) begin
                w[k*INPUT_WIDTH +: INPUT_WIDTH] = beat;
            end
        end
        return w;
    endfunction

    // Accumulation stage state
    logic [CNT_W-1:0]        cnt_p0;
    logic [OUTPUT_WIDTH-1:0] acc_p0;
    logic                    flush_pend;

    // Output register stage
    logic [OUTPUT_WIDTH-1:0] out_data_p1;
    logic [MAX_CNT-1:0]      out_keep_p1;
    logic                    out_last_p1;
    logic                    vld_p1;
    logic                    flush_done_p1;

    // Handshake and control decode
    logic                    out_free;
    logic                    at_last;
    logic                    in_ready_c;
    logic                    accept;
    logic                    flush_take;
    logic                    flush_fire;

    // Next-state values
    logic [CNT_W-1:0]        cnt_nxt;
    logic [OUTPUT_WIDTH-1:0] acc_nxt;
    logic [OUTPUT_WIDTH-1:0] acc_wr;
    logic                    pend_nxt;
    logic                    load;
    logic [OUTPUT_WIDTH-1:0] load_data;
    logic [MAX_CNT-1:0]      load_keep;
    logic                    load_last;

    // The output slot is free when empty or when its word leaves this edge.
    assign out_free   = !vld_p1 || bus.out_ready;
    assign at_last    = (cnt_p0 == LAST_LANE);
    // The last lane may only be taken if the finished word has somewhere to go;
    // a pending flush blocks new beats until the partial word is closed.
    assign in_ready_c = !flush_pend && (!at_last || out_free);
    assign accept     = bus.in_valid && in_ready_c;
    // A flush pulse arriving while one is already pending is dropped.
    assign flush_take = bus.flush && !flush_pend;
    assign flush_fire = flush_pend && out_free;

    // Next-state decode for lane counter, accumulator, flush flag and output load.
    always_comb begin
        acc_wr    = lane_insert(acc_p0, cnt_p0, bus.in_data);
        cnt_nxt   = cnt_p0;
        acc_nxt   = acc_p0;
        pend_nxt  = flush_pend;
        load      = 1'b0;
        load_data = acc_p0;
        load_keep = '0;
        load_last = 1'b0;

        if (flush_fire) begin
            // Close the partial word; with no lanes collected nothing is emitted.
            pend_nxt = 1'b0;
            if (cnt_p0 != '0) begin
                load      = 1'b1;
                load_data = acc_p0;
                load_keep = lane_mask(cnt_p0);
                load_last = 1'b1;
            end
            cnt_nxt = '0;
            acc_nxt = '0;
        end else begin
            if (accept) begin
                if (at_last) begin
                    // Word completes this edge; a flush in the same cycle tags it last
                    // and leaves nothing behind for the flush to emit.
                    load      = 1'b1;
                    load_data = acc_wr;
                    load_keep = KEEP_ALL;
                    load_last = flush_take;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                    acc_nxt = acc_wr;
                end
            end
            if (flush_take) begin
                pend_nxt = 1'b1;
            end
        end
    end

    // Accumulation stage: lane counter, partial word and flush-pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0     <= '0;
            acc_p0     <= '0;
            flush_pend <= 1'b0;
        end else begin
            cnt_p0     <= cnt_nxt;
            acc_p0     <= acc_nxt;
            flush_pend <= pend_nxt;
        end
    end

    // Output stage: hold the word until taken; a new word may replace it on the take edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p1   <= '0;
            out_keep_p1   <= '0;
            out_last_p1   <= 1'b0;
            vld_p1        <= 1'b0;
            flush_done_p1 <= 1'b0;
        end else begin
            if (load) begin
                out_data_p1 <= load_data;
                out_keep_p1 <= load_keep;
                out_last_p1 <= load_last;
                vld_p1      <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1      <= 1'b0;
            end
            flush_done_p1 <= flush_fire;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = out_data_p1;
    assign bus.out_keep   = out_keep_p1;
    assign bus.out_last   = out_last_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.flush_done = flush_done_p1;
endmodule

// File: tb/tb_packer.sv
// tb_packer: directed scenarios plus randomized traffic for the packer, with a
// queue-based reference model of words, lanes and flush state.
module tb_packer;
    localparam int IW   = 64;
    localparam int OW   = 512;
    localparam int MAXC = OW / IW;

    typedef struct {
        logic [OW-1:0]   data;
        logic [MAXC-1:0] keep;
        logic            last;
    } word_t;

    logic clk;
    logic rst_n;

    packer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .MAX_CNT(MAXC)) bus ();

    packer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .MAX_CNT(MAXC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters, stepped only by chk (compare process).
    int checks = 0;
    int errors = 0;

    // Reference model state (compare process only).
    logic [IW-1:0] lanes[$];
    word_t         outq[$];
    bit            pend   = 1'b0;
    bit            exp_fd = 1'b0;

    // Hand-computed expectations posted by the stimulus process.
    int              pin_seq  = 0;
    int              pin_seen = 0;
    string           pin_name;
    bit              pin_v;
    logic [OW-1:0]   pin_d;
    logic [MAXC-1:0] pin_k;
    bit              pin_l;
    bit              pin_fd;
    bit              pin_ir;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic word_t make_word(input bit last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        w.last = last;
        foreach (lanes[i]) begin
            w.data[i*IW +: IW] = lanes[i];
            w.keep[i]          = 1'b1;
        end
        return w;
    endfunction

    // Compare process: checks outputs every cycle, then advances the model to the next edge.
    initial begin
        bit ofree, mir, fire;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                chk("rst_out_valid",  OW'(bus.out_valid),  '0);
                chk("rst_out_data",   bus.out_data,        '0);
                chk("rst_out_keep",   OW'(bus.out_keep),   '0);
                chk("rst_out_last",   OW'(bus.out_last),   '0);
                chk("rst_flush_done", OW'(bus.flush_done), '0);
                lanes.delete();
                outq.delete();
                pend   = 1'b0;
                exp_fd = 1'b0;
            end else begin
                ofree = (outq.size() == 0) || bus.out_ready;
                mir   = !pend && ((lanes.size() != MAXC - 1) || ofree);
                fire  = pend && ofree;

                chk("out_valid",  OW'(bus.out_valid),  OW'(outq.size() != 0));
                if (outq.size() != 0) begin
                    chk("out_data", bus.out_data,      outq[0].data);
                    chk("out_keep", OW'(bus.out_keep), OW'(outq[0].keep));
                    chk("out_last", OW'(bus.out_last), OW'(outq[0].last));
                end
                chk("in_ready",   OW'(bus.in_ready),   OW'(mir));
                chk("flush_done", OW'(bus.flush_done), OW'(exp_fd));

                if (pin_seq != pin_seen) begin
                    pin_seen = pin_seq;
                    chk({pin_name, "_valid"}, OW'(bus.out_valid), OW'(pin_v));
                    if (pin_v) begin
                        chk({pin_name, "_data"}, bus.out_data,      pin_d);
                        chk({pin_name, "_keep"}, OW'(bus.out_keep), OW'(pin_k));
                        chk({pin_name, "_last"}, OW'(bus.out_last), OW'(pin_l));
                    end
                    chk({pin_name, "_flush_done"}, OW'(bus.flush_done), OW'(pin_fd));
                    chk({pin_name, "_in_ready"},   OW'(bus.in_ready),   OW'(pin_ir));
                end

                // Advance to the state after the coming rising edge.
                if (outq.size() != 0 && bus.out_ready) void'(outq.pop_front());
                exp_fd = fire;
                if (fire) begin
                    if (lanes.size() > 0) outq.push_back(make_word(1'b1));
                    lanes.delete();
                    pend = 1'b0;
                end else begin
                    if (bus.in_valid && mir) begin
                        lanes.push_back(bus.in_data);
                        if (lanes.size() == MAXC) begin
                            outq.push_back(make_word(bus.flush));
                            lanes.delete();
                        end
                    end
                    if (bus.flush && !pend) pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input bit v, input logic [OW-1:0] d,
                       input logic [MAXC-1:0] k, input bit l, input bit fd, input bit ir);
        pin_name = nm;
        pin_v    = v;
        pin_d    = d;
        pin_k    = k;
        pin_l    = l;
        pin_fd   = fd;
        pin_ir   = ir;
        pin_seq++;
    endtask

    // Word whose lane i holds base+i for the lowest n lanes, upper lanes zero.
    function automatic logic [OW-1:0] seq_word(input int base, input int n);
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*IW +: IW] = IW'(base + i);
        return w;
    endfunction

    task automatic send(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_data  = IW'(base + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Stimulus process
    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Eight beats 1..8 make one full word.
        bus.out_ready = 1'b1;
        send(1, 8);
        pin("t1_word", 1'b1,
            {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1},
            8'hFF, 1'b0, 1'b0, 1'b1);
        tick();

        // Sixteen back-to-back beats, no in_ready gap.
        send('h10, 16);
        tick();

        // Output stalled: first word held, beat 16 waits, then both move on one edge.
        bus.out_ready = 1'b0;
        send('h100, 15);
        bus.in_data  = IW'('h10F);
        bus.in_valid = 1'b1;
        pin("t2_stall", 1'b1, seq_word('h100, 8), 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        pin("t2_word2", 1'b1, seq_word('h108, 8), 8'hFF, 1'b0, 1'b0, 1'b1);
        tick();

        // Partial flush of three beats.
        bus.in_data  = IW'('hA);
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = IW'('hB);
        tick();
        bus.in_data = IW'('hC);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        pin("t3_pend", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        pin("t3_part", 1'b1, {320'h0, 64'hC, 64'hB, 64'hA}, 8'h07, 1'b1, 1'b1, 1'b1);
        send('hD0, 8);
        pin("t3_next", 1'b1, seq_word('hD0, 8), 8'hFF, 1'b0, 1'b0, 1'b1);
        tick();

        // Flush together with the completing beat.
        send('h81, 7);
        bus.in_data  = IW'('h88);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        pin("t4_full", 1'b1, seq_word('h81, 8), 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        pin("t4_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        pin("t4_none", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();

        // Flush with nothing collected and the output idle.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        pin("t5_pend", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        pin("t5_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        tick();

        // Flush while the output is stalled.
        bus.out_ready = 1'b0;
        send('h50, 10);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        tick();
        pin("t5_stall", 1'b1, seq_word('h50, 8), 8'hFF, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        pin("t5_part", 1'b1, seq_word('h58, 2), 8'h03, 1'b1, 1'b1, 1'b1);
        tick();

        // Asynchronous reset mid-operation, then a clean word.
        bus.out_ready = 1'b0;
        send('h60, 13);
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send('h70, 8);
        pin("t6_clean", 1'b1, seq_word('h70, 8), 8'hFF, 1'b0, 1'b0, 1'b1);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = {$urandom, $urandom};
            bus.out_ready = (c % 500 < 100) ? 1'b1 : ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
